// File: rtl/reg_write_back.sv
// Writeback stage owning the register-file write port. It merges the non-stallable ALU
// stream with buffered long-latency results and publishes per-register pending state.
module reg_write_back #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [SEL_W-1:0]         alu_sel,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ldu_valid,
  output logic                     ldu_ready,
  input  logic [SEL_W-1:0]         ldu_sel,
  input  logic [DATA_W-1:0]        ldu_data,
  output logic                     write_en,
  output logic [SEL_W-1:0]         write_sel,
  output logic [DATA_W-1:0]        write_data,
  output logic [(1<<SEL_W)-1:0]    pending_mask,
  output logic                     stall_req
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [SEL_W-1:0]  fifo_sel_q  [FIFO_DEPTH];
  logic [SEL_W-1:0]  fifo_sel_d  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              ready_q, ready_d;
  logic              write_en_q, write_en_d;
  logic [SEL_W-1:0]  write_sel_q, write_sel_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic alu_wr, fifo_ne, pop, push;

  // An ALU write during stall is a protocol violation and is dropped.
  assign alu_wr  = alu_valid && (alu_sel != '0) && !stall_q;
  assign fifo_ne = (count_q != '0);
  assign pop     = fifo_ne && (stall_q || !alu_wr);
  assign push    = ldu_valid && ready_q && (ldu_sel != '0);

  always_comb begin
    fifo_sel_d  = fifo_sel_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_sel_d[wr_ptr_q]  = ldu_sel;
      fifo_data_d[wr_ptr_q] = ldu_data;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CNT_W'(FIFO_DEPTH));
  end

  always_comb begin
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (fifo_ne && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
    stall_d = (starve_d == STV_W'(STARVE_LIMIT));
  end

  always_comb begin
    write_en_d   = 1'b0;
    write_sel_d  = write_sel_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_en_d   = 1'b1;
      write_sel_d  = fifo_sel_q[rd_ptr_q];
      write_data_d = fifo_data_q[rd_ptr_q];
    end else if (alu_wr) begin
      write_en_d   = 1'b1;
      write_sel_d  = alu_sel;
      write_data_d = alu_data;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pending_mask[fifo_sel_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
      end
    end
    if (write_en_q) begin
      pending_mask[write_sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      stall_q      <= 1'b0;
      ready_q      <= 1'b0;
      write_en_q   <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      stall_q      <= stall_d;
      ready_q      <= ready_d;
      write_en_q   <= write_en_d;
      write_sel_q  <= write_sel_d;
      write_data_q <= write_data_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    fifo_sel_q  <= fifo_sel_d;
    fifo_data_q <= fifo_data_d;
  end

  assign ldu_ready  = ready_q;
  assign stall_req  = stall_q;
  assign write_en   = write_en_q;
  assign write_sel  = write_sel_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_reg_write_back.sv
// Randomized self-checking bench for reg_write_back, compared each cycle against a
// queue-based model of the writeback arbitration.
module tb_reg_write_back;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [SW-1:0] alu_sel = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ldu_valid = 1'b0;
  logic          ldu_ready;
  logic [SW-1:0] ldu_sel = '0;
  logic [DW-1:0] ldu_data = '0;
  logic          write_en;
  logic [SW-1:0] write_sel;
  logic [DW-1:0] write_data;
  logic [15:0]   pending_mask;
  logic          stall_req;

  always #5 clk = ~clk;

  reg_write_back #(
    .DATA_W(DW), .SEL_W(SW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data),
    .ldu_valid(ldu_valid), .ldu_ready(ldu_ready), .ldu_sel(ldu_sel), .ldu_data(ldu_data),
    .write_en(write_en), .write_sel(write_sel), .write_data(write_data),
    .pending_mask(pending_mask), .stall_req(stall_req)
  );

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  bit            m_ready, m_stall, m_wen;
  int            m_starve;
  logic [SW-1:0] m_wsel;
  logic [DW-1:0] m_wdata;
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;

  wire [54:0] dut_vec = {write_en, write_sel, write_data, pending_mask, ldu_ready, stall_req};

  function automatic logic [15:0] exp_mask();
    logic [15:0] m = '0;
    foreach (mq[i]) m[mq[i].sel] = 1'b1;
    if (m_wen) m[m_wsel] = 1'b1;
    return m;
  endfunction

  function automatic logic [54:0] exp_vec();
    return {m_wen, m_wsel, m_wdata, exp_mask(), m_ready, m_stall};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ready = 0; m_stall = 0; m_wen = 0; m_starve = 0;
    m_wsel = '0; m_wdata = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUT.
  task automatic step();
    bit   alu_w, pop, hs;
    ent_t e;
    alu_w = alu_valid && (alu_sel != 0) && !m_stall;
    pop   = (mq.size() > 0) && (m_stall || !alu_w);
    hs    = ldu_valid && m_ready;
    if (pop) begin
      e = mq.pop_front();
      m_wen = 1; m_wsel = e.sel; m_wdata = e.data;
      m_starve = 0;
    end else begin
      if (mq.size() > 0 && m_starve < LIMIT) m_starve++;
      if (alu_w) begin
        m_wen = 1; m_wsel = alu_sel; m_wdata = alu_data;
      end else begin
        m_wen = 0;
      end
    end
    if (hs && ldu_sel != 0) begin
      e.sel = ldu_sel; e.data = ldu_data;
      mq.push_back(e);
    end
    m_stall = (m_starve == LIMIT);
    m_ready = (mq.size() < DEPTH);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Upstream must hold ALU traffic while stall is requested.
  always @(posedge clk) begin
    if (rst_n && stall_req && alu_valid && alu_sel != 0) begin
      errors++;
      $display("FAIL alu_during_stall cyc=%0d got alu_valid=1 exp alu_valid=0", cyc);
    end
  end

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec !== 55'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
    end
    rst_n = 1;
    model_reset();
    checks++;
    if (ldu_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got=%b exp=0", ldu_ready);
    end
    step();
    checks++;
    if (dut_vec !== exp_vec() || ldu_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_sel = 4'd3; alu_data = 32'hDEADBEEF;
    step();
    checks++;
    if ({write_en, write_sel, write_data} !== {1'b1, 4'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL alu_write got=%b/%0d/%h exp=1/3/deadbeef", write_en, write_sel, write_data);
    end
    alu_sel = 4'd0; alu_data = $urandom;
    step();
    checks++;
    if (write_en !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL alu_sel0 got=%h exp=%h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1'($urandom_range(0, 1)); alu_sel = 4'($urandom); alu_data = $urandom;
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL alu_random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    alu_valid = 0;
    step();
  endtask

  task automatic test_ldu_pair();
    alu_valid = 0;
    ldu_valid = 1; ldu_sel = 4'd5; ldu_data = 32'h11;
    step();
    checks++;
    if (write_en !== 1'b0 || pending_mask !== 16'h0020 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL ldu_push1 got=%h exp=%h", dut_vec, exp_vec());
    end
    ldu_sel = 4'd6; ldu_data = 32'h22;
    step();
    checks++;
    if ({write_en, write_sel, write_data} !== {1'b1, 4'd5, 32'h11} ||
        pending_mask !== 16'h0060) begin
      errors++; $display("FAIL ldu_write_r5 got=%h mask=%h exp mask=0060", dut_vec, pending_mask);
    end
    ldu_valid = 0;
    step();
    checks++;
    if ({write_en, write_sel, write_data} !== {1'b1, 4'd6, 32'h22} ||
        pending_mask !== 16'h0040) begin
      errors++; $display("FAIL ldu_write_r6 got=%h mask=%h exp mask=0040", dut_vec, pending_mask);
    end
    step();
    checks++;
    if (write_en !== 1'b0 || pending_mask !== 16'h0000 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL ldu_idle got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  // ALU busy every cycle while five entries are offered: fills, stalls, drains in order.
  task automatic test_fill();
    logic [SW-1:0] exp_order[$];
    logic [SW-1:0] got_order[$];
    int acc = 0;
    bit saw_full = 0, hs, same;
    for (int c = 0; c < 40; c++) begin
      alu_valid = !m_stall; alu_sel = 4'($urandom_range(1, 4)); alu_data = $urandom;
      ldu_valid = (acc < 5); ldu_sel = 4'(7 + acc); ldu_data = 32'h100 + acc;
      hs = ldu_valid && m_ready;
      step();
      if (hs) begin exp_order.push_back(ldu_sel); acc++; end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fill_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (write_en && write_sel >= 7 && write_sel <= 11) got_order.push_back(write_sel);
      if (acc == 4 && !saw_full) begin
        saw_full = 1;
        checks++;
        if (ldu_ready !== 1'b0 || (pending_mask & 16'h0780) !== 16'h0780) begin
          errors++; $display("FAIL fill_full got ready=%b mask=%h exp ready=0 mask=0780",
                             ldu_ready, pending_mask);
        end
      end
    end
    alu_valid = 0; ldu_valid = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL fill_drain cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (write_en && write_sel >= 7 && write_sel <= 11) got_order.push_back(write_sel);
    end
    same = (got_order.size() == 5) && (exp_order.size() == 5);
    if (same) foreach (got_order[i]) if (got_order[i] !== exp_order[i]) same = 0;
    checks++;
    if (!same) begin
      errors++; $display("FAIL fill_order got %0d writes exp 5 in arrival order", got_order.size());
    end
  endtask

  task automatic test_starve();
    int n = 0;
    alu_valid = 1; alu_sel = 4'd2; alu_data = $urandom;
    ldu_valid = 1; ldu_sel = 4'd12; ldu_data = 32'h00C0FFEE;
    step();
    ldu_valid = 0;
    while (n < 20) begin
      alu_valid = !m_stall; alu_data = $urandom;
      if (!alu_valid) break;
      step();
      n++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL starve_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
      if (stall_req === 1'b1) break;
    end
    checks++;
    if (n != LIMIT || stall_req !== 1'b1) begin
      errors++; $display("FAIL starve_latency got=%0d cycles exp=%0d", n, LIMIT);
    end
    alu_valid = 0;
    step();
    checks++;
    if ({write_en, write_sel, write_data, stall_req} !== {1'b1, 4'd12, 32'h00C0FFEE, 1'b0}) begin
      errors++; $display("FAIL starve_pop got=%b/%0d/%h stall=%b exp=1/12/00c0ffee stall=0",
                         write_en, write_sel, write_data, stall_req);
    end
    step();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_sel = 4'd4;
    for (int i = 0; i < 3; i++) begin
      alu_data = $urandom;
      ldu_valid = 1; ldu_sel = 4'(1 + i); ldu_data = $urandom;
      step();
    end
    ldu_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_vec !== 55'd0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", dut_vec);
    end
    model_reset();
    alu_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (write_en !== 1'b0 || ldu_ready !== 1'b1 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL reset_discard cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  // Random mix of both sources, holding an LDU offer until it is taken.
  task automatic test_random();
    bit pend = 0, hs;
    for (int c = 0; c < 400; c++) begin
      alu_valid = !m_stall && ($urandom_range(0, 2) != 0);
      alu_sel = 4'($urandom); alu_data = $urandom;
      if (!pend) begin
        ldu_valid = 1'($urandom_range(0, 1));
        ldu_sel = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
        ldu_data = $urandom;
        pend = ldu_valid;
      end
      hs = ldu_valid && m_ready;
      step();
      if (hs) pend = 0;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
      end
    end
    alu_valid = 0; ldu_valid = 0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldu_pair();
    test_fill();
    test_starve();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d exp finish before 100000", cyc);
    $fatal(1, "timeout");
  end

endmodule
